// File: rtl/dmem_port_arbiter_if.sv
// Bundles the two requester ports and the data-memory port of the dmem arbiter.
// Latency: none (wires only).
// Backpressure: rN_ready is the only stall signal; a requester holds rN_req and its fields until it sees ready.
//
// Signals:
//   rN_req/we/size/unsigned/addr/wdata : requester N -> arbiter, held stable until rN_ready
//   rN_ready/rvalid/rdata              : arbiter -> requester N
//   mem_en/we/addr/wdata               : arbiter -> memory
//   mem_rdata                          : memory -> arbiter, one cycle after a read strobe
interface dmem_port_arbiter_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 12
);
    logic                    r0_req;
    logic                    r0_we;
    logic [1:0]              r0_size;
    logic                    r0_unsigned;
    logic [ADDRESS_BITS-1:0] r0_addr;
    logic [DATA_WIDTH-1:0]   r0_wdata;
    logic                    r0_ready;
    logic                    r0_rvalid;
    logic [DATA_WIDTH-1:0]   r0_rdata;

    logic                    r1_req;
    logic                    r1_we;
    logic [1:0]              r1_size;
    logic                    r1_unsigned;
    logic [ADDRESS_BITS-1:0] r1_addr;
    logic [DATA_WIDTH-1:0]   r1_wdata;
    logic                    r1_ready;
    logic                    r1_rvalid;
    logic [DATA_WIDTH-1:0]   r1_rdata;

    logic                    mem_en;
    logic                    mem_we;
    logic [ADDRESS_BITS-3:0] mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    // Arbiter side.
    modport slave (
        input  r0_req, r0_we, r0_size, r0_unsigned, r0_addr, r0_wdata,
        output r0_ready, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_size, r1_unsigned, r1_addr, r1_wdata,
        output r1_ready, r1_rvalid, r1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester/memory side.
    modport master (
        output r0_req, r0_we, r0_size, r0_unsigned, r0_addr, r0_wdata,
        input  r0_ready, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_size, r1_unsigned, r1_addr, r1_wdata,
        input  r1_ready, r1_rvalid, r1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin share of one word-wide sync-read data memory between the core (port 0) and the ISP/debug loader (port 1); sub-word stores become read-modify-write.
// Latency from accept edge: word store writes in cycle 1; load rvalid in cycle 2; sub-word store reads in cycle 1, writes in cycle 2.
// Backpressure: rN_ready only in IDLE, one transaction in flight; a request arriving while busy waits.
//
// Ports:
//   clk_i : system clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : dmem_port_arbiter_if.slave (two requesters + memory port)
module dmem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 12
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dmem_port_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP,
        S_RMW_RD,
        S_RMW_WR
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    // Replace the addressed lane of old_w with the right-aligned new_d; other lanes untouched.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_d,
        input logic [1:0]  size,
        input logic [1:0]  off
    );
        logic [31:0] res;
        res = old_w;
        case (size)
            SZ_BYTE: res[{off, 3'b000} +: 8]      = new_d[7:0];
            SZ_HALF: res[{off[1], 4'b0000} +: 16] = new_d[15:0];
            default: res                          = new_d;
        endcase
        return res;
    endfunction

    // Pull the addressed lane down to bit 0 and sign- or zero-extend it.
    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: res = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Registered state
    state_t                  state_q;
    logic                    last_grant_q;   // port granted most recently; 1 after reset so port 0 wins the first tie
    logic                    gnt_q;          // port owning the transaction in flight
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    mem_en_q;
    logic                    mem_we_q;
    logic                    rvalid_q;

    // Arbitration and winner field mux (consumed only in IDLE)
    logic                    win0_d;
    logic                    win1_d;
    logic                    we_d;
    logic [1:0]              size_d;
    logic                    uns_d;
    logic [ADDRESS_BITS-1:0] addr_d;
    logic [DATA_WIDTH-1:0]   wdata_d;

    always_comb begin
        win0_d  = bus.r0_req & (~bus.r1_req | last_grant_q);
        win1_d  = bus.r1_req & (~bus.r0_req | ~last_grant_q);
        we_d    = win1_d ? bus.r1_we       : bus.r0_we;
        size_d  = win1_d ? bus.r1_size     : bus.r0_size;
        uns_d   = win1_d ? bus.r1_unsigned : bus.r0_unsigned;
        addr_d  = win1_d ? bus.r1_addr     : bus.r0_addr;
        wdata_d = win1_d ? bus.r1_wdata    : bus.r0_wdata;
    end

    // Gate with reset so no accept is signalled while the block is held in reset.
    logic idle_ok;
    assign idle_ok      = (state_q == S_IDLE) & ~rst_i;
    assign bus.r0_ready = idle_ok & win0_d;
    assign bus.r1_ready = idle_ok & win1_d;

    // Single FSM; memory strobes and rvalid are registered alongside the state they belong to.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            rvalid_q     <= 1'b0;
        end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            rvalid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win0_d | win1_d) begin
                        gnt_q        <= win1_d;
                        last_grant_q <= win1_d;
                        size_q       <= size_d;
                        uns_q        <= uns_d;
                        addr_q       <= addr_d;
                        wdata_q      <= wdata_d;
                        mem_en_q     <= 1'b1;
                        if (!we_d) begin
                            state_q <= S_READ;
                        end else if (size_d[1]) begin
                            state_q  <= S_WRITE;
                            mem_we_q <= 1'b1;
                        end else begin
                            // No byte enables on the memory: fetch the word first.
                            state_q <= S_RMW_RD;
                        end
                    end
                end
                S_WRITE: state_q <= S_IDLE;
                S_READ: begin
                    state_q  <= S_RESP;
                    rvalid_q <= 1'b1;
                end
                S_RESP: state_q <= S_IDLE;
                S_RMW_RD: begin
                    state_q  <= S_RMW_WR;
                    mem_en_q <= 1'b1;
                    mem_we_q <= 1'b1;
                end
                S_RMW_WR: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // Memory port: driven only from registers and the returning mem_rdata, never from requester inputs.
    assign bus.mem_en   = mem_en_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = addr_q[ADDRESS_BITS-1:2];

    always_comb begin
        bus.mem_wdata = '0;
        case (state_q)
            S_WRITE:  bus.mem_wdata = wdata_q;
            // mem_rdata here is the word fetched in RMW_RD.
            S_RMW_WR: bus.mem_wdata = lane_merge(bus.mem_rdata, wdata_q, size_q, addr_q[1:0]);
            default:  bus.mem_wdata = '0;
        endcase
    end

    // Load response: rdata held at zero outside the valid cycle.
    logic [DATA_WIDTH-1:0] load_data;
    assign load_data = lane_extract(bus.mem_rdata, size_q, addr_q[1:0], uns_q);

    assign bus.r0_rvalid = rvalid_q & ~gnt_q;
    assign bus.r1_rvalid = rvalid_q &  gnt_q;
    assign bus.r0_rdata  = bus.r0_rvalid ? load_data : '0;
    assign bus.r1_rdata  = bus.r1_rvalid ? load_data : '0;

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares one single-port, word-wide, synchronous-read data memory between two requesters: port 0 is the core data path (loads/stores), port 1 is the ISP/debug loader. It arbitrates round-robin, turns byte and halfword stores into read-modify-write sequences because the memory has no byte enables, and sign- or zero-extends sub-word loads. It sits between the core's memory stage and the data memory.

## Interface
- DATA_WIDTH, 32, data width; only 32 is supported.
- ADDRESS_BITS, 12, requester byte-address width.
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- rN_req  in  1  request, one per port, N in {0,1}.
  - Held with all fields stable until rN_ready.
- rN_we  in  1  1 = store, 0 = load.
- rN_size  in  2  00 = byte, 01 = halfword, 10 or 11 = word.
- rN_unsigned  in  1  zero-extend a sub-word load; ignored for word accesses.
- rN_addr  in  ADDRESS_BITS  byte address.
- rN_wdata  in  32  store data, right-aligned.
- rN_ready  out  1  accept pulse, one cycle.
- rN_rvalid  out  1  load data valid, one-cycle pulse.
- rN_rdata  out  32  extended load data; valid only while rN_rvalid is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDRESS_BITS-2  word index, equal to addr[ADDRESS_BITS-1:2].
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid the cycle after mem_en=1 with mem_we=0.

## Operation
- States: IDLE, WRITE, READ, RESP, RMW_RD, RMW_WR.
- Arbitration happens only in IDLE.
  - If only one port requests, that port wins.
  - If both request, the winner is the port not granted last.
  - last_grant resets to 1, so port 0 wins the first tie.
- Accept: the winner's rN_ready goes high combinationally in IDLE, and its fields are latched at that edge. The next state depends on the request:
  - word store: WRITE
  - load: READ
  - byte or halfword store: RMW_RD
- rN_ready is 0 in every state except IDLE. A request that arrives while busy waits.
- Memory outputs are decoded only from the state and latched registers. There is no combinational path from any rN_* input to any mem_* output.
- WRITE: mem_en=1, mem_we=1, mem_wdata = latched wdata. Next state is IDLE.
- READ: mem_en=1, mem_we=0. Next state is RESP.
- RESP: the granted port's rvalid=1, and rdata is the extracted, extended mem_rdata. Next state is IDLE.
- RMW_RD: mem_en=1, mem_we=0. Next state is RMW_WR.
- RMW_WR: mem_en=1, mem_we=1, mem_wdata = mem_rdata with the target lane replaced. Next state is IDLE.
- Lane selection:
  - byte: off = addr[1:0], lane is bits [8·off+7 : 8·off], fed from wdata[7:0].
  - halfword: lane is bits [16·addr[1]+15 : 16·addr[1]], fed from wdata[15:0]; addr[0] is ignored.
  - word: addr[1:0] is ignored.
- Loads extract the same lane, then sign-extend, or zero-extend if unsigned.
- Lanes outside the target are never modified.

## Timing
- Reset values: state=IDLE, last_grant=1, every output 0.
- rN_ready, rN_rvalid and mem_en/mem_we are all 0 while reset is high.
- Asserting reset in any state, including RMW_WR, forces IDLE immediately.
  - mem_we drops asynchronously, so an in-flight write is not performed.
  - An abandoned load produces no rvalid.
- Latency is counted from the accept edge, cycle 0:
  - word store: write strobe in cycle 1; next accept possible in cycle 2.
  - load: mem_en in cycle 1, rvalid in cycle 2; next accept possible in cycle 3.
  - sub-word store: read in cycle 1, write in cycle 2; next accept possible in cycle 3.
- No overlap: at most one transaction is in flight.
- A continuous single requester is accepted in every IDLE cycle.
- A port deasserting req before ready is allowed; it is simply not granted.

## Test plan
- Word store/load: r0 stores 0xDEADBEEF to 0x010.
  - Expect mem_addr=0x004 with a one-cycle mem_we pulse.
  - A following load word at 0x010 returns r0_rdata=0xDEADBEEF with r0_rvalid exactly 2 cycles after its ready.
- Halfword: the word at 0x010 is preset to 0x11223344; r0 does sh 0x8001 at 0x012.
  - The memory word becomes 0x80013344.
  - lh at 0x012 returns 0xFFFF8001; lhu returns 0x00008001.
- Byte: sb 0xA5 at 0x013 over 0x11223344.
  - The memory word becomes 0xA5223344.
  - lb returns 0xFFFFFFA5, lbu returns 0x000000A5, and lb at 0x010 still returns 0x00000044.
- Arbitration: both ports hold req with word loads after reset.
  - Grant order is r0, r1, r0, r1.
  - Each rvalid appears only on the granted port.
- Busy stall: r1 raises req during r0's RMW_RD.
  - r1_ready stays 0 until IDLE, then r1 is accepted and served.
- Reset mid-RMW: assert reset during RMW_WR.
  - mem_we goes to 0 the same cycle and the memory word is unchanged.
  - After release the block is in IDLE with all outputs 0, and the next tie goes to r0.
